// File: rtl/data_buffer_arbiter_if.sv
// Bundle of requester, buffer-RAM and status signals around the endpoint buffer arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus buffer RAM.
interface data_buffer_arbiter_if #(
    parameter int CNT_W = 7
);
    logic             ahb_store;
    logic [7:0]       ahb_wdata;
    logic             ahb_get;
    logic             ahb_busy;
    logic [7:0]       ahb_rdata;
    logic             ahb_rvalid;
    logic             usb_store;
    logic [7:0]       usb_wdata;
    logic             usb_get;
    logic             usb_busy;
    logic [7:0]       usb_rdata;
    logic             usb_rvalid;
    logic             clear;
    logic             buf_write;
    logic             buf_read;
    logic [7:0]       buf_wdata;
    logic [7:0]       buf_rdata;
    logic             buf_clear;
    logic [CNT_W-1:0] buffer_occupancy;
    logic             overflow;
    logic             underflow;
    logic             req_drop;

    modport slave (
        input  ahb_store, ahb_wdata, ahb_get, usb_store, usb_wdata, usb_get, clear, buf_rdata,
        output ahb_busy, ahb_rdata, ahb_rvalid, usb_busy, usb_rdata, usb_rvalid,
               buf_write, buf_read, buf_wdata, buf_clear, buffer_occupancy,
               overflow, underflow, req_drop
    );

    modport master (
        output ahb_store, ahb_wdata, ahb_get, usb_store, usb_wdata, usb_get, clear, buf_rdata,
        input  ahb_busy, ahb_rdata, ahb_rvalid, usb_busy, usb_rdata, usb_rvalid,
               buf_write, buf_read, buf_wdata, buf_clear, buffer_occupancy,
               overflow, underflow, req_drop
    );
endinterface

// File: rtl/data_buffer_arbiter.sv
// Round-robin arbiter giving the AHB and USB requesters one access per cycle to the
// single-port endpoint buffer; owns occupancy, overflow/underflow guarding and flushes.
module data_buffer_arbiter #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 n_rst,
    data_buffer_arbiter_if.slave bus
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state;
    logic             buf_clear_q;
    logic             ahb_vld_p0, ahb_wr_p0, usb_vld_p0, usb_wr_p0;
    logic [7:0]       ahb_data_p0, usb_data_p0;
    logic             last_usb;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q, udf_q, drop_q;
    logic             ahb_tag_p1, usb_tag_p1, ahb_zero_p1, usb_zero_p1;

    logic             run, gnt_ahb, gnt_usb, gnt_any, gnt_wr;
    logic [7:0]       gnt_data;
    logic             full, empty, do_write, do_read;
    logic             ahb_free, usb_free, ahb_req, usb_req, drop_evt;

    assign run = (state == RUN);

    // Tie goes to whichever requester was not served last
    always_comb begin
        gnt_ahb = 1'b0;
        gnt_usb = 1'b0;
        if (run) begin
            if (ahb_vld_p0 && usb_vld_p0) begin
                gnt_ahb = last_usb;
                gnt_usb = !last_usb;
            end else begin
                gnt_ahb = ahb_vld_p0;
                gnt_usb = usb_vld_p0;
            end
        end
    end

    assign gnt_any  = gnt_ahb | gnt_usb;
    assign gnt_wr   = gnt_ahb ? ahb_wr_p0 : usb_wr_p0;
    assign gnt_data = gnt_ahb ? ahb_data_p0 : usb_data_p0;
    assign full     = (cnt == FULL);
    assign empty    = (cnt == '0);
    assign do_write = gnt_any && gnt_wr && !full;
    assign do_read  = gnt_any && !gnt_wr && !empty;

    assign ahb_free = !ahb_vld_p0 || gnt_ahb;
    assign usb_free = !usb_vld_p0 || gnt_usb;
    assign ahb_req  = bus.ahb_store || bus.ahb_get;
    assign usb_req  = bus.usb_store || bus.usb_get;
    assign drop_evt = run && ((bus.ahb_store && bus.ahb_get) || (ahb_req && !ahb_free) ||
                              (bus.usb_store && bus.usb_get) || (usb_req && !usb_free));

    assign bus.buf_write        = do_write;
    assign bus.buf_read         = do_read;
    assign bus.buf_wdata        = do_write ? gnt_data : 8'h00;
    assign bus.buf_clear        = buf_clear_q;
    assign bus.buffer_occupancy = cnt;
    assign bus.overflow         = ovf_q;
    assign bus.underflow        = udf_q;
    assign bus.req_drop         = drop_q;
    assign bus.ahb_busy         = ahb_vld_p0;
    assign bus.usb_busy         = usb_vld_p0;

    // Read return: data from the RAM routed by last cycle's tag; a flush cycle swallows it
    assign bus.ahb_rvalid = ahb_tag_p1 && run;
    assign bus.usb_rvalid = usb_tag_p1 && run;
    assign bus.ahb_rdata  = (bus.ahb_rvalid && !ahb_zero_p1) ? bus.buf_rdata : 8'h00;
    assign bus.usb_rdata  = (bus.usb_rvalid && !usb_zero_p1) ? bus.buf_rdata : 8'h00;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= RUN;
            buf_clear_q <= 1'b0;
            ahb_vld_p0  <= 1'b0;
            ahb_wr_p0   <= 1'b0;
            usb_vld_p0  <= 1'b0;
            usb_wr_p0   <= 1'b0;
            last_usb    <= 1'b0;
            cnt         <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            drop_q      <= 1'b0;
            ahb_tag_p1  <= 1'b0;
            usb_tag_p1  <= 1'b0;
            ahb_zero_p1 <= 1'b0;
            usb_zero_p1 <= 1'b0;
        end else begin
            case (state)
                RUN: if (bus.clear) begin
                    state       <= FLUSH;
                    buf_clear_q <= 1'b1;
                end
                FLUSH: if (!bus.clear) begin
                    state       <= RUN;
                    buf_clear_q <= 1'b0;
                end
                default: begin
                    state       <= RUN;
                    buf_clear_q <= 1'b0;
                end
            endcase

            if (!run) begin
                ahb_vld_p0 <= 1'b0;
                usb_vld_p0 <= 1'b0;
                cnt        <= '0;
                ovf_q      <= 1'b0;
                udf_q      <= 1'b0;
                drop_q     <= 1'b0;
                ahb_tag_p1 <= 1'b0;
                usb_tag_p1 <= 1'b0;
            end else begin
                if (ahb_free) begin
                    ahb_vld_p0 <= ahb_req;
                    ahb_wr_p0  <= bus.ahb_store;
                end
                if (usb_free) begin
                    usb_vld_p0 <= usb_req;
                    usb_wr_p0  <= bus.usb_store;
                end
                if (gnt_any)
                    last_usb <= gnt_usb;
                if (do_write)
                    cnt <= cnt + ONE;
                else if (do_read)
                    cnt <= cnt - ONE;
                if (gnt_any && gnt_wr && full)
                    ovf_q <= 1'b1;
                if (gnt_any && !gnt_wr && empty)
                    udf_q <= 1'b1;
                if (drop_evt)
                    drop_q <= 1'b1;
                ahb_tag_p1  <= gnt_ahb && !ahb_wr_p0;
                usb_tag_p1  <= gnt_usb && !usb_wr_p0;
                ahb_zero_p1 <= empty;
                usb_zero_p1 <= empty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (run && ahb_free && bus.ahb_store)
            ahb_data_p0 <= bus.ahb_wdata;
        if (run && usb_free && bus.usb_store)
            usb_data_p0 <= bus.usb_wdata;
    end
endmodule

// File: tb/tb_data_buffer_arbiter.sv
// Bench for data_buffer_arbiter: queue-based reference of slots, buffer contents and flags,
// directed scenarios followed by randomized traffic, plus a behavioural buffer RAM.
module tb_data_buffer_arbiter;
    localparam int DEPTH = 64;

    logic clk;
    logic n_rst;
    int   checks = 0;
    int   errors = 0;

    data_buffer_arbiter_if #(.CNT_W(7)) bus ();

    data_buffer_arbiter #(.DEPTH(DEPTH), .CNT_W(7)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port FIFO RAM: read data appears the cycle after buf_read
    logic [7:0] mem [DEPTH];
    int         wp, rp;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wp <= 0;
            rp <= 0;
        end else if (bus.buf_clear) begin
            wp <= 0;
            rp <= 0;
        end else begin
            if (bus.buf_write) begin
                mem[wp] <= bus.buf_wdata;
                wp      <= (wp + 1) % DEPTH;
            end
            if (bus.buf_read) begin
                bus.buf_rdata <= mem[rp];
                rp            <= (rp + 1) % DEPTH;
            end
        end
    end

    // Reference state
    bit         pa_v, pa_w, pu_v, pu_w, last_usb;
    bit         m_ovf, m_udf, m_drop, m_flush, rv_a, rv_u;
    logic [7:0] pa_d, pu_d, rd_a, rd_u;
    logic [7:0] fifo[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pa_v = 0; pa_w = 0; pu_v = 0; pu_w = 0; last_usb = 0;
        m_ovf = 0; m_udf = 0; m_drop = 0; m_flush = 0; rv_a = 0; rv_u = 0;
        pa_d = 0; pu_d = 0; rd_a = 0; rd_u = 0;
        fifo.delete();
    endtask

    // 0 = nobody, 1 = AHB, 2 = USB
    task automatic winner(output int w);
        w = 0;
        if (!m_flush) begin
            if (pa_v && pu_v) w = last_usb ? 1 : 2;
            else if (pa_v)    w = 1;
            else if (pu_v)    w = 2;
        end
    endtask

    task automatic check_outputs();
        int         w;
        bit         ww, exp_wr, exp_rd, ea, eu;
        logic [7:0] wd;
        winner(w);
        ww     = (w == 1) ? pa_w : pu_w;
        wd     = (w == 1) ? pa_d : pu_d;
        exp_wr = (w != 0) && ww && (fifo.size() < DEPTH);
        exp_rd = (w != 0) && !ww && (fifo.size() > 0);
        ea     = rv_a && !m_flush;
        eu     = rv_u && !m_flush;
        chk("buf_write", 32'(bus.buf_write), 32'(exp_wr));
        if (exp_wr) chk("buf_wdata", 32'(bus.buf_wdata), 32'(wd));
        chk("buf_read", 32'(bus.buf_read), 32'(exp_rd));
        chk("ahb_rvalid", 32'(bus.ahb_rvalid), 32'(ea));
        if (ea) chk("ahb_rdata", 32'(bus.ahb_rdata), 32'(rd_a));
        chk("usb_rvalid", 32'(bus.usb_rvalid), 32'(eu));
        if (eu) chk("usb_rdata", 32'(bus.usb_rdata), 32'(rd_u));
        chk("ahb_busy", 32'(bus.ahb_busy), 32'(pa_v));
        chk("usb_busy", 32'(bus.usb_busy), 32'(pu_v));
        chk("occupancy", 32'(bus.buffer_occupancy), 32'(fifo.size()));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_udf));
        chk("req_drop", 32'(bus.req_drop), 32'(m_drop));
        chk("buf_clear", 32'(bus.buf_clear), 32'(m_flush));
    endtask

    task automatic slot_step(input logic st, input logic gt, input logic [7:0] wd, input bit won,
                             inout bit v, inout bit w, inout logic [7:0] d);
        if (st && gt) m_drop = 1;
        if (st || gt) begin
            if (!v || won) begin
                v = 1; w = st; d = wd;
            end else begin
                m_drop = 1;
            end
        end else if (won) begin
            v = 0;
        end
    endtask

    task automatic model_update();
        int         w;
        bit         ww;
        logic [7:0] wd, rdv;
        if (!n_rst) begin
            model_reset();
        end else begin
            if (m_flush) begin
                pa_v = 0; pu_v = 0; fifo.delete();
                m_ovf = 0; m_udf = 0; m_drop = 0; rv_a = 0; rv_u = 0;
            end else begin
                winner(w);
                rv_a = 0; rv_u = 0;
                if (w != 0) begin
                    ww = (w == 1) ? pa_w : pu_w;
                    wd = (w == 1) ? pa_d : pu_d;
                    if (ww) begin
                        if (fifo.size() < DEPTH) fifo.push_back(wd);
                        else m_ovf = 1;
                    end else begin
                        if (fifo.size() > 0) rdv = fifo.pop_front();
                        else begin rdv = 8'h00; m_udf = 1; end
                        if (w == 1) begin rv_a = 1; rd_a = rdv; end
                        else begin rv_u = 1; rd_u = rdv; end
                    end
                    last_usb = (w == 2);
                end
                slot_step(bus.ahb_store, bus.ahb_get, bus.ahb_wdata, w == 1, pa_v, pa_w, pa_d);
                slot_step(bus.usb_store, bus.usb_get, bus.usb_wdata, w == 2, pu_v, pu_w, pu_d);
            end
            m_flush = bus.clear;
        end
    endtask

    task automatic drive(input logic ast, input logic [7:0] awd, input logic agt,
                         input logic ust, input logic [7:0] uwd, input logic ugt, input logic clr);
        bus.ahb_store = ast; bus.ahb_wdata = awd; bus.ahb_get = agt;
        bus.usb_store = ust; bus.usb_wdata = uwd; bus.usb_get = ugt;
        bus.clear     = clr;
    endtask

    task automatic idle();
        drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic flush_now();
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        tick();
        idle();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r8;
        int         p;
        n_rst = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        repeat (3) tick();
        n_rst = 1'b1;
        tick();

        // Same-cycle stores: USB wins the first tie, AHB follows
        drive(1, 8'hA5, 0, 1, 8'h3C, 0, 0);
        tick();
        idle();
        chk("cont_wr1", 32'(bus.buf_write), 32'd1);
        chk("cont_wd1", 32'(bus.buf_wdata), 32'h3C);
        chk("cont_busy1", 32'(bus.ahb_busy), 32'd1);
        tick();
        chk("cont_wr2", 32'(bus.buf_write), 32'd1);
        chk("cont_wd2", 32'(bus.buf_wdata), 32'hA5);
        tick();
        chk("cont_occ", 32'(bus.buffer_occupancy), 32'd2);
        chk("cont_busy3", 32'(bus.ahb_busy), 32'd0);

        // Fill to capacity, then one store too many
        flush_now();
        for (int i = 0; i < DEPTH + 1; i++) begin
            r8 = 8'($urandom);
            drive(0, 8'h00, 0, 1, r8, 0, 0);
            tick();
        end
        idle();
        tick();
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_occ", 32'(bus.buffer_occupancy), 32'd64);

        // Drain with one get too many
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(0, 8'h00, 1, 0, 8'h00, 0, 0);
            tick();
        end
        idle();
        tick();
        chk("udf_zero", 32'(bus.ahb_rdata), 32'h00);
        chk("udf_rvalid", 32'(bus.ahb_rvalid), 32'd1);
        tick();
        chk("udf_flag", 32'(bus.underflow), 32'd1);
        chk("udf_occ", 32'(bus.buffer_occupancy), 32'd0);

        // Fairness under continuous gets from both sides
        flush_now();
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'(8'h10 + i), 0, 0, 8'h00, 0, 0);
            tick();
        end
        idle();
        tick();
        for (int k = 1; k <= 8; k++) begin
            drive(0, 8'h00, 1, 0, 8'h00, 1, 0);
            tick();
            if (k >= 2) begin
                chk("fair_usb", 32'(bus.usb_rvalid), 32'(k % 2 == 0));
                chk("fair_ahb", 32'(bus.ahb_rvalid), 32'(k % 2 == 1));
            end
        end
        chk("fair_drop", 32'(bus.req_drop), 32'd1);
        idle();
        tick();

        // Flush while both slots are pending and a read is in flight
        flush_now();
        drive(0, 8'h00, 0, 1, 8'h77, 0, 0); tick();
        drive(0, 8'h00, 0, 1, 8'h88, 0, 0); tick();
        idle(); tick();
        drive(0, 8'h00, 1, 0, 8'h00, 1, 0); tick();
        drive(0, 8'h00, 1, 0, 8'h00, 1, 1); tick();
        idle();
        chk("fl_clear", 32'(bus.buf_clear), 32'd1);
        chk("fl_rv_a", 32'(bus.ahb_rvalid), 32'd0);
        chk("fl_rv_u", 32'(bus.usb_rvalid), 32'd0);
        tick();
        chk("fl_clear_off", 32'(bus.buf_clear), 32'd0);
        chk("fl_busy", 32'({bus.ahb_busy, bus.usb_busy}), 32'd0);
        chk("fl_occ", 32'(bus.buffer_occupancy), 32'd0);
        chk("fl_flags", 32'({bus.overflow, bus.underflow, bus.req_drop}), 32'd0);

        // Store and get together: only the store survives
        drive(1, 8'h5A, 1, 0, 8'h00, 0, 0);
        tick();
        idle();
        chk("sg_write", 32'(bus.buf_write), 32'd1);
        chk("sg_read", 32'(bus.buf_read), 32'd0);
        chk("sg_drop", 32'(bus.req_drop), 32'd1);
        tick();

        // Randomized traffic with a reset dropped in mid-stream
        for (int i = 0; i < 2000; i++) begin
            p = ((i / 250) % 2 == 0) ? 80 : 20;
            bus.ahb_wdata = 8'($urandom);
            bus.usb_wdata = 8'($urandom);
            bus.ahb_store = 0; bus.ahb_get = 0; bus.usb_store = 0; bus.usb_get = 0;
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 99) < p) bus.ahb_store = 1; else bus.ahb_get = 1;
                if ($urandom_range(0, 19) == 0) begin bus.ahb_store = 1; bus.ahb_get = 1; end
            end
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 99) < p) bus.usb_store = 1; else bus.usb_get = 1;
            end
            bus.clear = ($urandom_range(0, 99) == 0);
            if (i == 1000) begin
                n_rst = 1'b0;
                #1;
                chk("rst_occ", 32'(bus.buffer_occupancy), 32'd0);
                chk("rst_strobes", 32'({bus.buf_write, bus.buf_read, bus.buf_clear}), 32'd0);
                chk("rst_rvalid", 32'({bus.ahb_rvalid, bus.usb_rvalid}), 32'd0);
                chk("rst_rdata", 32'({bus.ahb_rdata, bus.usb_rdata}), 32'd0);
                chk("rst_flags", 32'({bus.overflow, bus.underflow, bus.req_drop}), 32'd0);
                chk("rst_busy", 32'({bus.ahb_busy, bus.usb_busy}), 32'd0);
                model_reset();
            end
            if (i == 1003) n_rst = 1'b1;
            tick();
        end
        idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
